// File: rtl/spi_mlf_pkg.sv
// Shared types and helpers for the MLF SPI blocks.
// Mode decoding, FSM state encoding and width constants.
package spi_mlf_pkg;

    localparam int SYNC_DEPTH = 2;
    localparam int BYTE_W     = 8;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    function automatic logic spi_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_mlf_sync_edge.sv
// Multi-flop synchronizer with a history flop for edge detection.
// RST_VAL sets the idle level so reset never produces a false edge.
import spi_mlf_pkg::*;

module spi_mlf_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] pipe;
    logic                  hist;
    logic                  level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe <= {SYNC_DEPTH{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            pipe <= {pipe[SYNC_DEPTH-2:0], din};
            hist <= pipe[SYNC_DEPTH-1];
        end
    end

    assign level = pipe[SYNC_DEPTH-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_mlf.sv
// SPI peripheral endpoint with byte-wide DV/Ready core handshake.
// Optional sticky status flags: define SPI_SLAVE_MLF_STATUS_EN.
import spi_mlf_pkg::*;

module spi_slave_mlf #(
    parameter logic [1:0]        SPI_MODE     = 2'd0,
    parameter logic [BYTE_W-1:0] IDLE_TX_BYTE = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_TX_DV,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [BYTE_W-1:0] o_RX_Byte,
    input  logic              i_SPI_clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_OE
`ifdef SPI_SLAVE_MLF_STATUS_EN
    ,
    input  logic              i_Status_Clr,
    output logic              o_TX_Underrun,
    output logic              o_RX_Overrun
`endif
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);

    logic clk_rise;
    logic clk_fall;
    logic cs_rise;
    logic cs_fall;

    logic [SYNC_DEPTH-1:0] mosi_pipe;
    logic                  mosi_sync;

    state_t              state;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-2:0]   rx_shift;
    logic [BYTE_W-1:0]   tx_shift;
    logic [BYTE_W-1:0]   hold;
    logic [BYTE_W-1:0]   next_byte;

    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic in_frame;
    logic load;
    logic rx_done;

    spi_mlf_sync_edge #(
        .RST_VAL (CPOL)
    ) u_clk_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_SPI_clk),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    spi_mlf_sync_edge #(
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .din   (i_SPI_CS_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mosi_pipe <= '0;
        end else begin
            mosi_pipe <= {mosi_pipe[SYNC_DEPTH-2:0], i_SPI_MOSI};
        end
    end

    assign mosi_sync = mosi_pipe[SYNC_DEPTH-1];

    // Leading edge leaves the idle polarity, trailing edge returns to it.
    assign lead_edge   = CPOL ? clk_fall : clk_rise;
    assign trail_edge  = CPOL ? clk_rise : clk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign in_frame  = (state == ST_ACTIVE) && !cs_rise;
    assign next_byte = o_TX_Ready ? IDLE_TX_BYTE : hold;

    // CPHA=0 primes MISO on CS fall; every byte boundary reloads after.
    assign load = ((state == ST_IDLE) && cs_fall && !CPHA)
                || (in_frame && shift_edge && (bit_cnt == 3'd0));

    assign rx_done = in_frame && sample_edge && (bit_cnt == 3'd7);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            hold          <= '0;
            o_TX_Ready    <= 1'b1;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= '0;
            o_SPI_MISO_OE <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;

            // A strobe coinciding with an empty-load still lands in hold.
            if (i_TX_DV && o_TX_Ready) begin
                hold       <= i_TX_Byte;
                o_TX_Ready <= 1'b0;
            end else if (load) begin
                o_TX_Ready <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state         <= ST_ACTIVE;
                        bit_cnt       <= 3'd0;
                        o_SPI_MISO_OE <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state         <= ST_IDLE;
                        bit_cnt       <= 3'd0;
                        rx_shift      <= '0;
                        tx_shift      <= '0;
                        o_SPI_MISO_OE <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[BYTE_W-3:0], mosi_sync};
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        if (shift_edge && (bit_cnt != 3'd0)) begin
                            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            endcase

            if (rx_done) begin
                o_RX_Byte <= {rx_shift, mosi_sync};
                o_RX_DV   <= 1'b1;
            end

            if (load) begin
                tx_shift <= next_byte;
            end
        end
    end

    assign o_SPI_MISO = tx_shift[BYTE_W-1];

`ifdef SPI_SLAVE_MLF_STATUS_EN
    logic dv_recent;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_TX_Underrun <= 1'b0;
            o_RX_Overrun  <= 1'b0;
            dv_recent     <= 1'b0;
        end else begin
            dv_recent <= o_RX_DV;
            if (i_Status_Clr) begin
                o_TX_Underrun <= 1'b0;
                o_RX_Overrun  <= 1'b0;
            end
            if (load && o_TX_Ready) begin
                o_TX_Underrun <= 1'b1;
            end
            // Consumer had under two cycles to take the previous byte.
            if (rx_done && (o_RX_DV || dv_recent)) begin
                o_RX_Overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Directed bench: one slave per SPI mode driven by a behavioural master.
// Status flags are checked when SPI_SLAVE_MLF_STATUS_EN is defined.
`timescale 1ns/1ps

module tb_spi_slave_mlf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] sclk;
    logic [3:0] cs_n;
    logic [3:0] mosi;
    logic [3:0] tx_dv;
    logic [7:0] tx_byte [4];
    wire  [3:0] miso;
    wire  [3:0] oe;
    wire  [3:0] tx_ready;
    wire  [3:0] rx_dv;
    wire  [7:0] rx_byte [4];
`ifdef SPI_SLAVE_MLF_STATUS_EN
    logic [3:0] st_clr;
    wire  [3:0] underrun;
    wire  [3:0] overrun;
`endif

    int ntests = 0;
    int nfail  = 0;
    int dv_cnt [4] = '{0, 0, 0, 0};
    logic [15:0] rx_hist [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_mlf #(
            .SPI_MODE     (2'(g)),
            .IDLE_TX_BYTE (8'h00)
        ) u_dut (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_TX_Byte     (tx_byte[g]),
            .i_TX_DV       (tx_dv[g]),
            .o_TX_Ready    (tx_ready[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Byte     (rx_byte[g]),
            .i_SPI_clk     (sclk[g]),
            .i_SPI_CS_n    (cs_n[g]),
            .i_SPI_MOSI    (mosi[g]),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_OE (oe[g])
`ifdef SPI_SLAVE_MLF_STATUS_EN
            ,
            .i_Status_Clr  (st_clr[g]),
            .o_TX_Underrun (underrun[g]),
            .o_RX_Overrun  (overrun[g])
`endif
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_dv[k] === 1'b1) begin
                dv_cnt[k]  <= dv_cnt[k] + 1;
                rx_hist[k] <= {rx_hist[k][7:0], rx_byte[k]};
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input int d, input logic [7:0] b);
        @(negedge clk);
        tx_byte[d] = b;
        tx_dv[d]   = 1'b1;
        @(negedge clk);
        tx_dv[d]   = 1'b0;
    endtask

    // Behavioural master, half period of 4 clocks, MSB-first from mo[15].
    task automatic frame(input int d, input int nbits,
                         input logic [15:0] mo, output logic [15:0] mi);
        logic [1:0] m;
        logic cpol;
        logic cpha;
        m    = 2'(d);
        cpol = m[1];
        cpha = m[0];
        mi   = '0;
        @(negedge clk);
        cs_n[d] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) mosi[d] = mo[15-i];
            repeat (4) @(negedge clk);
            if (!cpha) mi[15-i] = miso[d];
            sclk[d] = ~cpol;
            if (cpha) mosi[d] = mo[15-i];
            repeat (4) @(negedge clk);
            if (cpha) mi[15-i] = miso[d];
            sclk[d] = cpol;
            if (i == 0) check($sformatf("oe_active_m%0d", d),
                              16'(oe[d]), 16'h1);
        end
        repeat (6) @(negedge clk);
        cs_n[d] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

`ifdef SPI_SLAVE_MLF_STATUS_EN
    task automatic clr_status();
        @(negedge clk);
        st_clr = 4'hF;
        @(negedge clk);
        st_clr = 4'h0;
    endtask
`endif

    initial begin
        logic [15:0] mi;
        int          dvb;

        rst_n   = 1'b0;
        sclk    = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 4'h0;
        tx_dv   = 4'h0;
        tx_byte = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SPI_SLAVE_MLF_STATUS_EN
        st_clr  = 4'h0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 16'(tx_ready), 16'hF);
        check("rst_dv", 16'(rx_dv), 16'h0);
        check("rst_oe", 16'(oe), 16'h0);
        check("rst_miso", 16'(miso), 16'h0);
        check("rst_rxbyte", 16'(rx_byte[3]), 16'h0);

        // Mode 3: slave A5, master C1
        load(3, 8'hA5);
        check("m3_ready_full", 16'(tx_ready[3]), 16'h0);
        dvb = dv_cnt[3];
        frame(3, 8, 16'hC100, mi);
        check("m3_rx", 16'(rx_byte[3]), 16'h00C1);
        check("m3_dv_pulses", 16'(dv_cnt[3] - dvb), 16'h1);
        check("m3_miso", mi, 16'hA500);
        check("m3_ready_after", 16'(tx_ready[3]), 16'h1);
        check("m3_oe_idle", 16'(oe[3]), 16'h0);

        // Modes 0..2: slave 96, master 3C
        for (int d = 0; d < 3; d++) begin
            load(d, 8'h96);
            dvb = dv_cnt[d];
            frame(d, 8, 16'h3C00, mi);
            check($sformatf("m%0d_rx", d), 16'(rx_byte[d]), 16'h003C);
            check($sformatf("m%0d_miso", d), mi, 16'h9600);
            check($sformatf("m%0d_dv", d), 16'(dv_cnt[d] - dvb), 16'h1);
            check($sformatf("m%0d_oe_idle", d), 16'(oe[d]), 16'h0);
        end

        // Mode 0: two-byte frame, holding refilled mid-frame
        load(0, 8'h12);
        dvb = dv_cnt[0];
        fork
            frame(0, 16, 16'hBEEF, mi);
            begin
                repeat (20) @(negedge clk);
                check("m0_ready_refill", 16'(tx_ready[0]), 16'h1);
                load(0, 8'h34);
            end
        join
        check("m0_two_rx", rx_hist[0], 16'hBEEF);
        check("m0_two_dv", 16'(dv_cnt[0] - dvb), 16'h2);
        check("m0_two_miso", mi, 16'h1234);

        // Mode 1: second byte finds holding empty
`ifdef SPI_SLAVE_MLF_STATUS_EN
        clr_status();
        check("m1_under_clr0", 16'(underrun[1]), 16'h0);
`endif
        load(1, 8'h77);
        frame(1, 16, 16'h1122, mi);
        check("m1_idle_miso", mi, 16'h7700);
        check("m1_two_rx", rx_hist[1], 16'h1122);
        check("m1_ready", 16'(tx_ready[1]), 16'h1);
`ifdef SPI_SLAVE_MLF_STATUS_EN
        check("m1_underrun", 16'(underrun[1]), 16'h1);
        clr_status();
        check("m1_under_clr", 16'(underrun[1]), 16'h0);
        check("m1_overrun", 16'(overrun[1]), 16'h0);
`endif

        // Mode 2: abort after 5 bits, then a clean byte
        dvb = dv_cnt[2];
        frame(2, 5, 16'hF800, mi);
        check("m2_abort_dv", 16'(dv_cnt[2] - dvb), 16'h0);
        check("m2_abort_rx", 16'(rx_byte[2]), 16'h003C);
        check("m2_abort_oe", 16'(oe[2]), 16'h0);
        load(2, 8'hC3);
        dvb = dv_cnt[2];
        frame(2, 8, 16'h5A00, mi);
        check("m2_after_rx", 16'(rx_byte[2]), 16'h005A);
        check("m2_after_dv", 16'(dv_cnt[2] - dvb), 16'h1);
        check("m2_after_miso", mi, 16'hC300);

        // Mode 3: reset mid-byte
        load(3, 8'hE7);
        @(negedge clk);
        cs_n[3] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            sclk[3] = 1'b0;
            repeat (4) @(negedge clk);
            sclk[3] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("rstmid_pre_oe", 16'(oe[3]), 16'h1);
        check("rstmid_pre_miso", 16'(miso[3]), 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_oe", 16'(oe[3]), 16'h0);
        check("rstmid_miso", 16'(miso[3]), 16'h0);
        check("rstmid_rx", 16'(rx_byte[3]), 16'h0);
        check("rstmid_dv", 16'(rx_dv[3]), 16'h0);
        check("rstmid_ready", 16'(tx_ready[3]), 16'h1);
        cs_n[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        load(3, 8'h81);
        dvb = dv_cnt[3];
        frame(3, 8, 16'h7E00, mi);
        check("post_rst_rx", 16'(rx_byte[3]), 16'h007E);
        check("post_rst_dv", 16'(dv_cnt[3] - dvb), 16'h1);
        check("post_rst_miso", mi, 16'h8100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
